search_sched: RTL and testbench
===============================

SEARCH_SCHED -- requirements
Module: search_sched

Interface
REQ-001 Parameter DATA_W, default 8: width of the search target.
REQ-002 Parameter ADDR_W, default 5: width of the searcher result address (32-entry RAM).
REQ-003 Parameter TIMEOUT, default 64: maximum cycles in RUN before the operation is aborted.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 req  input  2  per-requester level request; held until that requester's rsp_valid.
REQ-007 target0, target1  input  DATA_W each  search value for requester 0 and 1; sampled at grant.
REQ-008 gnt  output  2  one-hot owner of the searcher; all-zero when idle.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 rsp_valid  output  2  one-cycle pulse to the served requester.
REQ-011 rsp_found, rsp_err  output  1 each  result flags, valid while rsp_valid is nonzero.
REQ-012 rsp_addr  output  ADDR_W  match address, valid while rsp_valid is nonzero.
REQ-013 srch_start  output  1  level start to the searcher.
REQ-014 srch_target  output  DATA_W  target to the searcher; held stable while srch_start is high.
REQ-015 srch_done, srch_found  input  1 each  searcher status.
REQ-016 srch_addr  input  ADDR_W  searcher result address.

Function
REQ-017 FSM states: IDLE, RUN, RESP, DRAIN.
REQ-018 IDLE: if any req bit is high, the block SHALL grant one requester and enter RUN on the next edge.
  - Same edge: target latched into srch_target; gnt set; timeout counter cleared.
REQ-019 Arbitration SHALL be round-robin.
  - Single requester: granted.
  - Both requesters: grant goes to the requester not served last; last_served updates at grant.
  - After reset, requester 0 wins a tie.
REQ-020 RUN: srch_start SHALL be 1 and the timeout counter SHALL increment every cycle.
REQ-021 RUN: when srch_done is sampled high, the block SHALL register srch_found/srch_addr and enter RESP.
REQ-022 RUN: when the counter reaches TIMEOUT-1 without srch_done, the block SHALL enter RESP with rsp_err=1, rsp_found=0, rsp_addr=0.
  - If srch_done and the timeout occur in the same cycle, srch_done wins (rsp_err=0).
REQ-023 RESP lasts exactly one cycle.
  - rsp_valid bit of the granted requester = 1; srch_start = 0; then DRAIN.
REQ-024 DRAIN: srch_start = 0; the block SHALL remain in DRAIN until srch_done is sampled low, then enter IDLE with gnt cleared.
REQ-025 Latency, request to rsp_valid: 1 (grant) + searcher cycles + 1. Minimum 3 cycles.
REQ-026 A req deassertion after grant SHALL NOT abort the operation; the response is still pulsed.
REQ-027 A req still high in IDLE after its response is a new request and is arbitrated normally.
REQ-028 Changes on target0/target1 after grant SHALL NOT affect srch_target.
REQ-029 rsp_found, rsp_err and rsp_addr SHALL hold their last values until the next RESP.
REQ-030 gnt SHALL stay constant from grant through DRAIN.

Reset
REQ-031 On reset low the block SHALL immediately force the following, including mid-operation (no response pulsed):
  - state = IDLE;
  - gnt, rsp_valid = 0; rsp_found, rsp_err = 0; rsp_addr = 0;
  - srch_start = 0; srch_target = 0;
  - last_served = requester 1; timeout counter = 0.

Structure
REQ-032 Shared package search_pkg SHALL hold the FSM state enum and the default DATA_W, ADDR_W and TIMEOUT constants.
REQ-033 A sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant (inputs req, last_served; output one-hot grant).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Single request: req=01, target0=8'h2A; searcher model done after 6 cycles, found=1, addr=5'd9 -> gnt=01, srch_target=2A, rsp_valid=01 with found=1, addr=9, err=0.
REQ-036 Simultaneous requests after reset: req=11 -> requester 0 served first, then requester 1 without a third grant; rsp_valid=01 then 10.
REQ-037 Timeout: searcher never asserts done -> after TIMEOUT cycles in RUN, rsp_valid pulses with err=1, found=0, addr=0; block leaves DRAIN once done is low.
REQ-038 Drain hold: searcher keeps done high for 4 cycles after start drops -> no new grant until done is low, even with req=10 pending.
REQ-039 Reset mid-RUN: assert reset 3 cycles into RUN -> all outputs 0 asynchronously, no rsp_valid; after release, req=10 is granted normally.
REQ-040 Target stability: change target0 from 8'h2A to 8'h55 during RUN -> srch_target stays 8'h2A.

Source files
------------

// File: rtl/search_pkg.sv
// Shared types and default sizing for the two-requester search scheduler.
package search_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_served ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/search_sched.sv
// Shares one searcher between two requesters: grant, run with timeout,
// pulse a response, then wait for the searcher to drop done before idling.
module search_sched
    import search_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] target0,
    input  logic [DATA_W-1:0] target1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic [1:0]        rsp_valid,
    output logic              rsp_found,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              srch_start,
    output logic [DATA_W-1:0] srch_target,
    input  logic              srch_done,
    input  logic              srch_found,
    input  logic [ADDR_W-1:0] srch_addr,
    output state_t            dbg_state
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              last_served, last_d;
    logic [1:0]        gnt_d, rsp_valid_d, arb_gnt;
    logic              busy_d, found_d, err_d, start_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] target_d;

    rr_arbiter2 u_arb (
        .req         (req),
        .last_served (last_served),
        .grant       (arb_gnt)
    );

    // Every output is the registered copy of a next-value computed here.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_d      = last_served;
        gnt_d       = gnt;
        rsp_valid_d = 2'b00;
        found_d     = rsp_found;
        err_d       = rsp_err;
        addr_d      = rsp_addr;
        start_d     = srch_start;
        target_d    = srch_target;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_d  = S_RUN;
                    gnt_d    = arb_gnt;
                    last_d   = arb_gnt[1];
                    target_d = arb_gnt[1] ? target1 : target0;
                    cnt_d    = '0;
                    start_d  = 1'b1;
                end
            end
            S_RUN: begin
                // done takes priority over a coincident timeout
                if (srch_done) begin
                    state_d     = S_RESP;
                    found_d     = srch_found;
                    addr_d      = srch_addr;
                    err_d       = 1'b0;
                    rsp_valid_d = gnt;
                    start_d     = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_d     = S_RESP;
                    found_d     = 1'b0;
                    addr_d      = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = gnt;
                    start_d     = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!srch_done) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last_served <= 1'b1;
            gnt         <= 2'b00;
            busy        <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_found   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_addr    <= '0;
            srch_start  <= 1'b0;
            srch_target <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_served <= last_d;
            gnt         <= gnt_d;
            busy        <= busy_d;
            rsp_valid   <= rsp_valid_d;
            rsp_found   <= found_d;
            rsp_err     <= err_d;
            rsp_addr    <= addr_d;
            srch_start  <= start_d;
            srch_target <= target_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_search_sched.sv
// Bench for search_sched: directed vector table, hand-written reset sequence,
// then randomized operations against a round-robin / timeout reference model.
module tb_search_sched;
    import search_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [DW-1:0] target0 = '0;
    logic [DW-1:0] target1 = '0;
    logic [1:0]    gnt, rsp_valid;
    logic          busy, rsp_found, rsp_err, srch_start;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] srch_target;
    logic          srch_done = 1'b0;
    logic          srch_found = 1'b0;
    logic [AW-1:0] srch_addr = '0;
    state_t        dbg_state;

    search_sched #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .target0     (target0),
        .target1     (target1),
        .gnt         (gnt),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_found   (rsp_found),
        .rsp_err     (rsp_err),
        .rsp_addr    (rsp_addr),
        .srch_start  (srch_start),
        .srch_target (srch_target),
        .srch_done   (srch_done),
        .srch_found  (srch_found),
        .srch_addr   (srch_addr),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_last = 1;

    typedef struct {
        logic [1:0]    req;
        logic [DW-1:0] t0;
        logic [DW-1:0] t1;
        int            lat;
        logic          fnd;
        logic [AW-1:0] addr;
        int            hold;
        logic [1:0]    extra;
        bit            chg;
        bit            drop;
        logic [1:0]    exp_gnt;
        logic          exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic [DW-1:0] t0, input logic [DW-1:0] t1,
                                input int lat, input logic fnd, input logic [AW-1:0] addr,
                                input int hold, input logic [1:0] extra, input bit chg,
                                input bit drop, input logic [1:0] eg, input logic ee);
        vec_t v;
        v.req = r; v.t0 = t0; v.t1 = t1; v.lat = lat; v.fnd = fnd; v.addr = addr;
        v.hold = hold; v.extra = extra; v.chg = chg; v.drop = drop;
        v.exp_gnt = eg; v.exp_err = ee;
        return v;
    endfunction

    // Reference arbitration: a lone requester wins; a tie goes to the one not served last.
    function automatic logic [1:0] model_gnt(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
        return r;
    endfunction

    // lat = RUN cycle (0-based) in which the searcher raises done; hold = extra cycles
    // done stays high once the response is out.
    task automatic run_op(input vec_t v);
        int            idx, cyc, hc, h_eff, exp_rsp_cyc;
        bit            done_on, seen;
        logic [DW-1:0] exp_tgt;
        logic          e_found;
        logic [AW-1:0] e_addr;
        idx     = v.exp_gnt[1] ? 1 : 0;
        exp_tgt = (idx == 1) ? v.t1 : v.t0;
        req     = v.req;
        target0 = v.t0;
        target1 = v.t1;
        @(negedge clk);
        chk("grant", gnt, v.exp_gnt);
        chk("srch_target", srch_target, exp_tgt);
        chk("srch_start_run", srch_start, 1);
        chk("busy_run", busy, 1);
        chk("state_run", dbg_state, S_RUN);
        if (v.drop) req[idx] = 1'b0;
        cyc = 0; done_on = 0; seen = 0;
        for (int k = 0; k < TO + 4; k++) begin
            if (cyc == v.lat) begin
                srch_done = 1'b1; srch_found = v.fnd; srch_addr = v.addr; done_on = 1;
            end
            if (v.chg && cyc == 1) begin
                target0 = 8'h55; target1 = 8'h55;
            end
            @(negedge clk);
            cyc++;
            if (rsp_valid != 2'b00) begin
                seen = 1;
                break;
            end
            if (v.chg) chk("target_stable", srch_target, exp_tgt);
        end
        chk("rsp_seen", seen, 1);
        exp_rsp_cyc = (v.lat < TO) ? v.lat + 1 : TO;
        e_found = v.exp_err ? 1'b0 : v.fnd;
        e_addr  = v.exp_err ? '0 : v.addr;
        chk("rsp_latency", cyc, exp_rsp_cyc);
        chk("rsp_valid", rsp_valid, v.exp_gnt);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_found", rsp_found, e_found);
        chk("rsp_addr", rsp_addr, e_addr);
        chk("srch_start_resp", srch_start, 0);
        req = (req & ~v.exp_gnt) | v.extra;
        h_eff = done_on ? v.hold : 0;
        hc = 0; seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (hc == h_eff) srch_done = 1'b0;
            @(negedge clk);
            hc++;
            if (!busy) begin
                seen = 1;
                break;
            end
            chk("drain_gnt", gnt, v.exp_gnt);
            chk("drain_rsp_valid", rsp_valid, 0);
        end
        chk("drain_exit", seen, 1);
        chk("drain_cycles", hc, ((h_eff < 1) ? 1 : h_eff) + 1);
        chk("idle_gnt", gnt, 0);
        chk("hold_found", rsp_found, e_found);
        chk("hold_err", rsp_err, v.exp_err);
        chk("hold_addr", rsp_addr, e_addr);
        srch_found = 1'b0;
        exp_last = idx;
    endtask

    initial begin
        vec_t v;
        // Reset state, checked while reset is held.
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_srch_start", srch_start, 0);
        chk("rst_srch_target", srch_target, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //           req    t0     t1     lat fnd addr  hold extra chg drop egnt   eerr
        tbl[0]  = mk(2'b11, 8'h11, 8'h22, 2,  1, 5'd3,  0, 2'b00, 0, 0, 2'b01, 1'b0);
        tbl[1]  = mk(2'b10, 8'h11, 8'h22, 0,  0, 5'd7,  1, 2'b00, 0, 0, 2'b10, 1'b0);
        tbl[2]  = mk(2'b01, 8'h2A, 8'h00, 5,  1, 5'd9,  0, 2'b00, 0, 0, 2'b01, 1'b0);
        tbl[3]  = mk(2'b10, 8'h00, 8'h3C, 99, 1, 5'd4,  0, 2'b00, 0, 0, 2'b10, 1'b1);
        tbl[4]  = mk(2'b01, 8'h01, 8'h02, TO-1, 1, 5'd31, 0, 2'b00, 0, 0, 2'b01, 1'b0);
        tbl[5]  = mk(2'b01, 8'h03, 8'h04, TO, 1, 5'd17, 0, 2'b00, 0, 0, 2'b01, 1'b1);
        tbl[6]  = mk(2'b01, 8'h77, 8'h88, 1,  1, 5'd2,  4, 2'b10, 0, 0, 2'b01, 1'b0);
        tbl[7]  = mk(2'b10, 8'h77, 8'h88, 3,  0, 5'd0,  0, 2'b00, 0, 0, 2'b10, 1'b0);
        tbl[8]  = mk(2'b01, 8'h2A, 8'h99, 6,  1, 5'd12, 2, 2'b00, 1, 0, 2'b01, 1'b0);
        tbl[9]  = mk(2'b11, 8'hC0, 8'hC1, 4,  1, 5'd21, 0, 2'b00, 0, 0, 2'b10, 1'b0);
        tbl[10] = mk(2'b01, 8'hC0, 8'hC1, 2,  0, 5'd5,  3, 2'b00, 0, 0, 2'b01, 1'b0);
        tbl[11] = mk(2'b10, 8'hD0, 8'hD1, 3,  1, 5'd30, 0, 2'b00, 0, 1, 2'b10, 1'b0);
        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        // Reset three cycles into RUN: outputs clear at once, nothing is pulsed.
        req = 2'b01; target0 = 8'hA5;
        @(negedge clk);
        chk("mid_gnt", gnt, 2'b01);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", srch_start, 0);
        chk("mid_rst_target", srch_target, 0);
        chk("mid_rst_state", dbg_state, S_IDLE);
        req = 2'b00;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        exp_last = 1;
        @(negedge clk);
        run_op(mk(2'b10, 8'h00, 8'h6B, 2, 1, 5'd8, 0, 2'b00, 0, 0, 2'b10, 1'b0));
        run_op(mk(2'b11, 8'h4D, 8'h6B, 1, 1, 5'd1, 0, 2'b00, 0, 0, 2'b01, 1'b0));

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            v.req   = 2'($urandom_range(1, 3));
            v.t0    = DW'($urandom);
            v.t1    = DW'($urandom);
            v.lat   = $urandom_range(0, TO + 3);
            v.fnd   = 1'($urandom_range(0, 1));
            v.addr  = AW'($urandom);
            v.hold  = $urandom_range(0, 3);
            v.extra = 2'b00;
            v.chg   = 1'($urandom_range(0, 1));
            v.drop  = 1'($urandom_range(0, 1));
            v.exp_gnt = model_gnt(v.req, exp_last);
            v.exp_err = (v.lat >= TO);
            run_op(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
